// File: rtl/seq_divider_16by8.sv
// Sequential unsigned restoring divider: N_WIDTH-bit dividend by D_WIDTH-bit divisor,
// one quotient bit per clock, MSB first, with a start/busy/done handshake.
module seq_divider_16by8 #(
    parameter int unsigned N_WIDTH = 16,
    parameter int unsigned D_WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [N_WIDTH-1:0] dividend,
    input  logic [D_WIDTH-1:0] divisor,
    output logic               busy,
    output logic               done,
    output logic [N_WIDTH-1:0] quotient,
    output logic [D_WIDTH-1:0] remainder,
    output logic               div_by_zero
);

    localparam int unsigned CntW = (N_WIDTH > 1) ? $clog2(N_WIDTH) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e             state_q, state_d;
    // Dividend shifts out of the MSB while quotient bits shift into the LSB.
    logic [N_WIDTH-1:0] dvd_q, dvd_d;
    logic [D_WIDTH-1:0] dvs_q, dvs_d;
    logic [D_WIDTH:0]   pr_q, pr_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [N_WIDTH-1:0] quo_q, quo_d;
    logic [D_WIDTH-1:0] rem_q, rem_d;
    logic               dbz_q, dbz_d;
    logic [D_WIDTH:0]   trial;
    logic               qbit;

    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        pr_d    = pr_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        trial   = {pr_q[D_WIDTH-1:0], dvd_q[N_WIDTH-1]};
        qbit    = (trial >= {1'b0, dvs_q});

        unique case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (start) begin
                    if (divisor == '0) begin
                        state_d = StDone;
                        quo_d   = '1;
                        rem_d   = dividend[D_WIDTH-1:0];
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = StRun;
                        dvd_d   = dividend;
                        dvs_d   = divisor;
                        pr_d    = '0;
                        cnt_d   = CntW'(N_WIDTH - 1);
                    end
                end
            end
            StRun: begin
                pr_d  = qbit ? (trial - {1'b0, dvs_q}) : trial;
                dvd_d = {dvd_q[N_WIDTH-2:0], qbit};
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = StDone;
                    quo_d   = dvd_d;
                    rem_d   = pr_d[D_WIDTH-1:0];
                    dbz_d   = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            dvd_q   <= '0;
            dvs_q   <= '0;
            pr_q    <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            pr_q    <= pr_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = (state_q == StRun);
    assign done        = (state_q == StDone);
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider_16by8.sv
// Directed self-checking bench for seq_divider_16by8 with hand-computed results.
module tb_seq_divider_16by8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] dividend = '0;
    logic [7:0]  divisor = '0;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        div_by_zero;

    int n_checks = 0;
    int n_fail   = 0;

    seq_divider_16by8 #(.N_WIDTH(16), .D_WIDTH(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present operands, let the next edge (edge 0) accept them, then scramble inputs.
    task automatic start_op(input logic [15:0] dvd, input logic [7:0] dvs);
        start    = 1'b1;
        dividend = dvd;
        divisor  = dvs;
        step();
        start    = 1'b0;
        dividend = 16'hA5A5;
        divisor  = 8'h11;
    endtask

    task automatic wait_done(input int max, output int n);
        n = 0;
        while (!done && n < max) begin
            step();
            n++;
        end
    endtask

    task automatic run_div(input string tag, input logic [15:0] dvd, input logic [7:0] dvs,
                           input logic [15:0] exp_q, input logic [7:0] exp_r,
                           input logic exp_dbz, input int exp_lat);
        int lat;
        start_op(dvd, dvs);
        check_eq({tag, " busy after accept"}, busy, (exp_lat > 0));
        wait_done(40, lat);
        check_eq({tag, " latency"}, lat, exp_lat);
        check_eq({tag, " quotient"}, quotient, exp_q);
        check_eq({tag, " remainder"}, remainder, exp_r);
        check_eq({tag, " div_by_zero"}, div_by_zero, exp_dbz);
        step();
        check_eq({tag, " done one cycle"}, done, 0);
        check_eq({tag, " quotient held"}, quotient, exp_q);
    endtask

    initial begin
        int lat;
        int extra;
        int k;

        step();
        step();
        rst = 1'b0;
        check_eq("reset busy", busy, 0);
        check_eq("reset done", done, 0);
        check_eq("reset quotient", quotient, 0);
        check_eq("reset remainder", remainder, 0);
        check_eq("reset div_by_zero", div_by_zero, 0);

        run_div("1000/3", 16'd1000, 8'd3, 16'd333, 8'd1, 1'b0, 16);
        run_div("65025/255", 16'd65025, 8'd255, 16'd255, 8'd0, 1'b0, 16);
        run_div("65535/1", 16'd65535, 8'd1, 16'd65535, 8'd0, 1'b0, 16);
        run_div("5/9", 16'd5, 8'd9, 16'd0, 8'd5, 1'b0, 16);
        run_div("0/7", 16'd0, 8'd7, 16'd0, 8'd0, 1'b0, 16);
        run_div("div0", 16'h04D2, 8'd0, 16'hFFFF, 8'hD2, 1'b1, 0);
        run_div("10/2", 16'd10, 8'd2, 16'd5, 8'd0, 1'b0, 16);

        // Start held high with other operands while busy must be ignored.
        start_op(16'd1000, 8'd3);
        k = 0;
        while (!done && k < 40) begin
            step();
            k++;
            if (k == 2) begin
                start    = 1'b1;
                dividend = 16'd50;
                divisor  = 8'd5;
            end
            if (k == 10) start = 1'b0;
        end
        check_eq("ignore latency", k, 16);
        check_eq("ignore quotient", quotient, 333);
        check_eq("ignore remainder", remainder, 1);
        extra = 0;
        for (int i = 0; i < 24; i++) begin
            step();
            if (done) extra++;
        end
        check_eq("ignore no second done", extra, 0);

        // Back-to-back: new start in the DONE cycle.
        start_op(16'd1000, 8'd3);
        wait_done(40, lat);
        check_eq("b2b first latency", lat, 16);
        start_op(16'd255, 8'd16);
        check_eq("b2b done drops", done, 0);
        check_eq("b2b busy", busy, 1);
        check_eq("b2b first result held", quotient, 333);
        for (int i = 0; i < 8; i++) step();
        check_eq("b2b held mid-run", remainder, 1);
        wait_done(40, lat);
        check_eq("b2b second latency", lat + 8, 16);
        check_eq("b2b quotient", quotient, 15);
        check_eq("b2b remainder", remainder, 15);
        step();

        // Reset mid-operation aborts without a done pulse.
        start_op(16'd1000, 8'd3);
        for (int i = 0; i < 7; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("midrst busy", busy, 0);
        check_eq("midrst done", done, 0);
        check_eq("midrst quotient", quotient, 0);
        check_eq("midrst remainder", remainder, 0);
        check_eq("midrst div_by_zero", div_by_zero, 0);
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (done || busy) extra++;
        end
        check_eq("midrst stays idle", extra, 0);
        run_div("77/7", 16'd77, 8'd7, 16'd11, 8'd0, 1'b0, 16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/seq_divider_16by8.md
Name: seq_divider_16by8

Overview:
- Sequential unsigned restoring divider. It is the inverse of the team's 8x8 multipliers: it takes a 16-bit dividend (a product-width value) and an 8-bit divisor, and returns a 16-bit quotient and an 8-bit remainder.
- Computes one quotient bit per clock, MSB first.
- Uses a start/busy/done handshake and sits beside the multiplier library as the arithmetic-unit divide path.

Parameters:
- N_WIDTH, 16, dividend and quotient width in bits.
- D_WIDTH, 8, divisor and remainder width in bits; must satisfy D_WIDTH <= N_WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- dividend  input  N_WIDTH  unsigned dividend; sampled with start.
- divisor  input  D_WIDTH  unsigned divisor; sampled with start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse; results valid.
- quotient  output  N_WIDTH  result quotient.
- remainder  output  D_WIDTH  result remainder.
- div_by_zero  output  1  set with done when divisor was 0.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst. While rst=1 at an edge: state=IDLE; busy, done, quotient, remainder and div_by_zero all 0; internal registers cleared. Reset mid-operation aborts the operation with no done pulse.
- States: IDLE, RUN, DONE.
- Accept rule: start is accepted at an edge when state is IDLE or DONE (busy=0). start while busy=1 is ignored, and the operands on that cycle are not captured.
- Accept with divisor != 0:
  - Capture dividend into a shift register, divisor into a holding register, partial remainder (D_WIDTH+1 bits) = 0, bit counter = N_WIDTH-1.
  - Go to RUN; busy=1 from the next cycle.
- RUN iteration, one per edge:
  - t = {pr[D_WIDTH-1:0], dividend_msb}, D_WIDTH+1 bits.
  - If t >= {0,divisor}: pr = t - divisor and qbit = 1; else pr = t and qbit = 0.
  - Shift qbit into the quotient LSB and shift the dividend left.
  - Count down. On the iteration with counter=0, go to DONE and register quotient/remainder outputs (remainder = pr[D_WIDTH-1:0]).
- Latency: N_WIDTH edges. The edge that accepts start is edge 0. done=1 and busy=0 are visible after edge N_WIDTH (16 for defaults). busy is high after edges 0..N_WIDTH-1.
- Accept with divisor == 0: go directly to DONE at the accepting edge. quotient = all ones, remainder = dividend[D_WIDTH-1:0], div_by_zero = 1. done is visible after edge 0, i.e. 1-cycle latency.
- div_by_zero: cleared to 0 on any accepted start with nonzero divisor. It is updated together with quotient/remainder.
- DONE: lasts exactly one cycle. done=1 only in DONE. Next state is IDLE, or the start path if start=1 (back-to-back); done deasserts regardless.
- Result hold: quotient, remainder and div_by_zero change only at the edge entering DONE, or on reset. They hold their values through IDLE and the RUN phase of a subsequent operation.
- Results are exact for all operands: dividend = quotient*divisor + remainder, remainder < divisor. The quotient may use all N_WIDTH bits, e.g. 65535/1.
- Dividend/divisor inputs may change freely after the accepting edge; the captured copies are used.

Test Plan:
- Basic division: dividend=16'd1000, divisor=8'd3, start for 1 cycle -> busy high for 16 cycles; done pulses once after edge 16; quotient=333, remainder=1, div_by_zero=0.
- Extremes: 65025/255 -> q=255, r=0. 65535/1 -> q=65535, r=0. 5/9 -> q=0, r=5. 0/7 -> q=0, r=0. Each with done exactly 16 edges after accept.
- Divide by zero: dividend=16'h04D2, divisor=0 -> done after edge 0 (1 cycle); quotient=16'hFFFF, remainder=8'hD2, div_by_zero=1. A following 10/2 -> q=5, r=0, div_by_zero=0.
- Start ignored while busy: start 1000/3, then start=1 with 50/5 at cycles 3..10 -> single done at edge 16 with q=333, r=1; no second done.
- Back-to-back: start=1 in the DONE cycle with 255/16 -> done deasserts next cycle; second done 16 edges later with q=15, r=15; first result held until then.
- Reset mid-operation: start 1000/3, assert rst at cycle 8 for 1 cycle -> all outputs 0, busy=0, no done. Then 77/7 -> q=11, r=0 after 16 edges.
